// File: rtl/perf_counters_pkg.sv
// Shared definitions for the performance-counter block: register offsets,
// CTRL bit positions, the default ID constant and a byte-lane merge helper.
package perf_counters_pkg;

  // Word offsets on adr_i.
  typedef enum logic [2:0] {
    ADR_CTRL    = 3'd0,
    ADR_CYC_LO  = 3'd1,
    ADR_CYC_HI  = 3'd2,
    ADR_INSN_LO = 3'd3,
    ADR_INSN_HI = 3'd4,
    ADR_LIMIT   = 3'd5,
    ADR_ID      = 3'd6,
    ADR_RSVD    = 3'd7
  } reg_adr_e;

  // CTRL register bit positions.
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_HALT   = 2;

  // Value returned by the ID register unless overridden ("perf" in ASCII).
  localparam logic [31:0] ID_DEFAULT = 32'h7065_7266;

  // Merge new data into an old word one byte lane at a time.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/perf_counter64.sv
// 64-bit event counter with synchronous clear; clear wins over increment.
module perf_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [63:0] count
);

  logic [63:0] count_q;

  // Count register: reset and clear both zero it, otherwise step on inc.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop in the
    // design samples pre-edge values regardless of block ordering.
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/perf_counters.sv
// Wishbone-attached cycle / retired-instruction counters with HI-word
// snapshots, an optional cycle limit and a sticky halt request to the core.
module perf_counters
  import perf_counters_pkg::*;
#(
  parameter logic [31:0] LIMIT_INIT = 32'h0,
  parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [2:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        retire_i,
  output logic        halt_o
);

  logic        req;
  logic        wr_req;
  logic        rd_req;
  reg_adr_e    adr;
  logic        ctrl_wr;
  logic        clear;
  logic        enable;
  logic [31:0] limit;
  logic        limit_hit;
  logic        count_en;
  logic [63:0] cyc_count;
  logic [63:0] insn_count;
  logic [31:0] cyc_hi_snap;
  logic [31:0] insn_hi_snap;
  logic [31:0] rd_value;

  // A new access is accepted only when no ack is outstanding, so a held
  // strobe produces one access every two cycles.
  assign req     = cyc_i & stb_i & ~ack_o;
  assign wr_req  = req & we_i;
  assign rd_req  = req & ~we_i;
  assign adr     = reg_adr_e'(adr_i);
  assign ctrl_wr = wr_req & (adr == ADR_CTRL) & sel_i[0];
  assign clear   = ctrl_wr & dat_i[CTRL_CLEAR];

  // The limit compare uses the registered count. Gating the increment with
  // the compare as well keeps the counter parked exactly at LIMIT during the
  // one cycle before halt_o rises.
  assign limit_hit = (limit != 32'd0) && (cyc_count >= {32'd0, limit});
  assign count_en  = enable & ~halt_o & ~limit_hit;

  perf_counter64 u_cyc (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (count_en),
    .count (cyc_count)
  );

  perf_counter64 u_insn (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (count_en & retire_i),
    .count (insn_count)
  );

  // Read mux for the addressed register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_value = '0;
    case (adr)
      ADR_CTRL:    rd_value[CTRL_HALT:CTRL_ENABLE] = {halt_o, 1'b0, enable};
      ADR_CYC_LO:  rd_value = cyc_count[31:0];
      ADR_CYC_HI:  rd_value = cyc_hi_snap;
      ADR_INSN_LO: rd_value = insn_count[31:0];
      ADR_INSN_HI: rd_value = insn_hi_snap;
      ADR_LIMIT:   rd_value = limit;
      ADR_ID:      rd_value = ID_VALUE;
      default:     rd_value = '0;
    endcase
  end

  // Bus response: ack one cycle after each accepted request; read data is
  // only driven during the ack cycle of a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req;
      dat_o <= rd_req ? rd_value : 32'd0;
    end
  end

  // HI snapshots latch the upper word at the edge that ends a LO read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_hi_snap  <= '0;
      insn_hi_snap <= '0;
    end else begin
      if (rd_req && adr == ADR_CYC_LO)  cyc_hi_snap  <= cyc_count[63:32];
      if (rd_req && adr == ADR_INSN_LO) insn_hi_snap <= insn_count[63:32];
    end
  end

  // Control/limit registers and the sticky halt request.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b1;
      limit  <= LIMIT_INIT;
      halt_o <= 1'b0;
    end else begin
      if (ctrl_wr) enable <= dat_i[CTRL_ENABLE];
      if (wr_req && adr == ADR_LIMIT) limit <= merge_bytes(limit, dat_i, sel_i);
      if ((ctrl_wr && dat_i[CTRL_HALT]) || limit_hit) halt_o <= 1'b1;
    end
  end

endmodule
